// File: rtl/mem_responder.sv
// mem_responder: fixed-latency, single-outstanding main-memory responder for the cache-to-memory interface.
//   Optional build macro MEM_BOUNDS_CHECK_EN adds the mem_error port and out-of-range address detection.
//   Ports: clk, reset (async active-low), mem_strobe/mem_RW/mem_addr/mem_data_in (request from cache),
//          mem_data_out/mem_ready (response), busy (request in flight), mem_error (bounds build only).
module mem_responder #(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_strobe,
  input  logic                 mem_RW,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_data_in,
  output logic [31:0]          mem_data_out,
  output logic                 mem_ready,
  output logic                 busy
`ifdef MEM_BOUNDS_CHECK_EN
  ,output logic                mem_error
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [ADDR_BITS-1:0] idx, req_idx;
  logic rw, req_rw, req_oob, capture;
  logic [31:0] wdata, req_data;
  logic [31:0] mem [DEPTH] = '{default: 32'h0};
  logic unused_bits;
  assign unused_bits = ^{mem_addr[31:ADDR_BITS+2], mem_addr[1:0]};
  assign capture = state == IDLE && mem_strobe;
  // The request seen at the DONE-entry edge comes straight from the inputs when LATENCY=1,
  // otherwise from the values latched at capture.
  assign req_idx  = state == IDLE ? mem_addr[ADDR_BITS+1:2] : idx;
  assign req_rw   = state == IDLE ? mem_RW : rw;
  assign req_data = state == IDLE ? mem_data_in : wdata;
  assign busy     = state != IDLE;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    state_nx = state == IDLE ? (mem_strobe ? (LATENCY == 1 ? DONE : BUSY) : IDLE)
             : state == BUSY ? (cnt == 4'd1 ? DONE : BUSY)
             : IDLE;
    cnt_nx   = capture ? 4'(LATENCY - 1) : state == BUSY ? cnt - 4'd1 : cnt;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      rw           <= 1'b0;
      wdata        <= '0;
      mem_ready    <= 1'b0;
      mem_data_out <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      mem_ready <= state_nx == DONE;
      if (capture) begin
        idx   <= req_idx;
        rw    <= req_rw;
        wdata <= req_data;
      end
      if (state_nx == DONE && !req_rw)
        mem_data_out <= req_oob ? 32'hDEADBEEF : mem[req_idx];
    end
  end
  // Storage has no reset; a write commits only on the edge entering DONE, so an aborted request never lands.
  always_ff @(posedge clk) begin
    if (reset && state_nx == DONE && req_rw && !req_oob)
      mem[req_idx] <= req_data;
  end
`ifdef MEM_BOUNDS_CHECK_EN
  logic oob;
  assign req_oob = state == IDLE ? |mem_addr[31:ADDR_BITS+2] : oob;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oob       <= 1'b0;
      mem_error <= 1'b0;
    end else begin
      if (capture) oob <= req_oob;
      mem_error <= state_nx == DONE && req_oob;
    end
  end
`else
  assign req_oob = 1'b0;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: self-checking bench for mem_responder against a word-array reference model.
module tb_mem_responder;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic reset, mem_strobe, mem_RW, mem_ready, busy;
  logic [31:0] mem_addr, mem_data_in, mem_data_out;
`ifdef MEM_BOUNDS_CHECK_EN
  logic mem_error;
`endif
  int passed = 0;
  int total = 0;
  int fails = 0;
  logic [31:0] ref_mem [1024];
  logic [31:0] last_out = 32'h0;
  always #5 clk = ~clk;
  mem_responder #(.DEPTH(1024), .ADDR_BITS(10), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .mem_strobe(mem_strobe), .mem_RW(mem_RW),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_ready(mem_ready), .busy(busy)
`ifdef MEM_BOUNDS_CHECK_EN
    , .mem_error(mem_error)
`endif
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic int idx(input logic [31:0] a);
    return int'((a >> 2) % 1024);
  endfunction
  function automatic logic is_oob(input logic [31:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
    return (a >> 12) != 0;
`else
    return a == 32'hFFFF_FFFF && a != a;
`endif
  endfunction
  task automatic xact(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] na, input logic [31:0] nd);
    int lat;
    logic oob;
    oob = is_oob(addr);
    mem_strobe = 1'b1;
    mem_RW = rw;
    mem_addr = addr;
    mem_data_in = data;
    tick();
    mem_strobe = 1'b0;
    mem_addr = na;
    mem_data_in = nd;
    check("busy_after_capture", 32'(busy), 32'd1);
    lat = 1;
    while (!mem_ready && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(LAT));
    if (!rw) last_out = oob ? 32'hDEADBEEF : ref_mem[idx(addr)];
    else if (!oob) ref_mem[idx(addr)] = data;
    check(rw ? "data_out_hold" : "read_data", mem_data_out, last_out);
`ifdef MEM_BOUNDS_CHECK_EN
    check("mem_error", 32'(mem_error), 32'(oob));
`endif
    tick();
    check("ready_one_cycle", 32'(mem_ready), 32'd0);
    check("busy_back_idle", 32'(busy), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] a;
    foreach (ref_mem[k]) ref_mem[k] = 32'h0;
    reset = 1'b0;
    mem_strobe = 1'b0;
    mem_RW = 1'b0;
    mem_addr = 32'h0;
    mem_data_in = 32'h0;
    repeat (3) tick();
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_data", mem_data_out, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_ready", 32'(mem_ready), 32'd0);
      check("idle_data", mem_data_out, 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
    xact(1'b1, 32'h10, 32'h12345678, 32'h10, 32'h12345678);
    xact(1'b0, 32'h10, 32'h0, 32'h10, 32'h0);
    xact(1'b1, 32'h10, 32'hCAFEF00D, 32'h20, 32'h0);
    xact(1'b0, 32'h10, 32'h0, 32'h0, 32'h0);
    xact(1'b0, 32'h20, 32'h0, 32'h0, 32'h0);
    mem_strobe = 1'b1;
    mem_RW = 1'b0;
    mem_addr = 32'h10;
    for (int c = 1; c <= 12; c++) begin
      tick();
      check("held_ready", 32'(mem_ready), 32'(c % 4 == 3));
      if (c % 4 == 3) check("held_data", mem_data_out, ref_mem[4]);
    end
    mem_strobe = 1'b0;
    last_out = ref_mem[4];
    repeat (6) tick();
    check("held_quiet", 32'(mem_ready), 32'd0);
    mem_strobe = 1'b1;
    mem_RW = 1'b1;
    mem_addr = 32'h40;
    mem_data_in = 32'hAAAA5555;
    tick();
    mem_strobe = 1'b0;
    check("abort_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_ready", 32'(mem_ready), 32'd0);
    check("abort_busy_clr", 32'(busy), 32'd0);
    check("abort_data_clr", mem_data_out, 32'd0);
    last_out = 32'h0;
    repeat (2) tick();
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("abort_no_ready", 32'(mem_ready), 32'd0);
    end
    xact(1'b0, 32'h40, 32'h0, 32'h0, 32'h0);
    xact(1'b1, 32'h1000, 32'h1, 32'h0, 32'h0);
    xact(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    xact(1'b0, 32'h1000, 32'h0, 32'h0, 32'h0);
    for (int n = 0; n < 60; n++) begin
      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a | (32'($urandom) << 12);
      xact(1'($urandom_range(0, 1)), a, $urandom, $urandom, $urandom);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Main-memory responder for the cache-to-memory request interface; sits on the memory side of the write-through cache.
- Accepts one strobed read or write at a time and models a fixed access latency.
- Returns read data and a one-cycle `mem_ready` pulse.
- Provides backing storage for cached and uncached CPU accesses.

Parameters:
- DEPTH, 1024, number of 32-bit words stored (power of two).
- ADDR_BITS, 10, log2(DEPTH); word index width.
- LATENCY, 3, cycles from request capture to `mem_ready` pulse (legal 1..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous active-low reset.
- mem_strobe  input  1  request valid from cache.
- mem_RW  input  1  1 = write, 0 = read.
- mem_addr  input  32  byte address; word index = mem_addr[ADDR_BITS+1:2]; bits [1:0] ignored.
- mem_data_in  input  32  write data from cache.
- mem_data_out  output  32  read data to cache.
- mem_ready  output  1  one-cycle completion pulse.
- busy  output  1  high while a request is in flight (BUSY or DONE state).

Behaviour:
- Reset (reset=0, async): state=IDLE, mem_ready=0, mem_data_out=0, busy=0, latency counter=0.
  - Storage array is not cleared by reset; it is zero-filled at time 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If mem_strobe=1 at a rising edge: latch addr index, mem_RW and mem_data_in; load counter=LATENCY-1; go to BUSY.
  - If LATENCY=1, go directly to DONE.
  - Otherwise stay in IDLE.
- BUSY:
  - Decrement counter each cycle.
  - When counter reaches 0, go to DONE on the next edge.
  - Inputs are ignored; a changing mem_addr or mem_data_in does not affect the latched request.
  - A mem_strobe drop does not abort the request.
- DONE (exactly one cycle):
  - mem_ready=1.
  - Read: mem_data_out = mem[latched index], registered, valid in the same cycle as mem_ready.
  - Write: mem[latched index] <= latched data at the edge entering DONE; mem_data_out holds its previous value.
  - Next state is IDLE.
- Latency: mem_ready rises exactly LATENCY cycles after the capturing edge.
- Throughput: one request per LATENCY+1 cycles.
- Back-to-back requests: if mem_strobe is still 1 in the IDLE cycle after DONE, it is captured as a new request. The requester deasserts mem_strobe on seeing mem_ready.
- Read-after-write to the same address returns the new data.
- Reset mid-request: request aborted; a pending write is not committed; mem_ready is not pulsed.
- mem_ready is never high for two consecutive cycles.
- Address wrap: index bits above ADDR_BITS+1 are ignored, so the address aliases modulo DEPTH words.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- Defined:
  - Extra output port `mem_error` (1 bit, reset 0).
  - If any of mem_addr[31:ADDR_BITS+2] is nonzero at capture, the request still completes with normal latency, and in DONE: mem_error=1 together with mem_ready.
  - Writes to such an address are discarded; reads return 32'hDEADBEEF.
  - mem_error pulses for exactly one cycle.
- Undefined:
  - No mem_error port.
  - Addresses alias modulo DEPTH as described above.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, no strobe for 10 cycles -> mem_ready=0, mem_data_out=0, busy=0 throughout.
- Write/read, LATENCY=3:
  - Write 32'h12345678 to addr 32'h0000_0010 -> mem_ready pulses on cycle 3 after capture.
  - Then read addr 32'h10 -> mem_data_out=32'h12345678 with mem_ready on cycle 3.
- Input stability: change mem_addr to 32'h20 and mem_data_in to 0 during BUSY of a write to 32'h10 -> word 4 holds the original data; word 8 unchanged.
- Held strobe: keep mem_strobe=1 for 12 cycles with LATENCY=3 -> mem_ready pulses every 4 cycles, never two cycles wide.
- Reset mid-write: assert reset one cycle after capturing a write of 32'hAAAA5555 to 32'h40 -> no mem_ready; subsequent read of 32'h40 returns the prior value (0).
- Bounds (MEM_BOUNDS_CHECK_EN, DEPTH=1024):
  - Write 32'h1 to 32'h0000_1000 -> mem_error=1 with mem_ready; word 0 unchanged.
  - Read 32'h0000_1000 -> 32'hDEADBEEF.
  - Without the macro, the same write lands in word 0.
